pano_init_seq: RTL

- Power-up and reset sequencer for the Pano bringup design, clocked from osc_clk (100 MHz).
- Waits for the clock generator lock to be stable, then releases per-domain resets in fixed order, one domain at a time.
- Monitors lock loss and software reset requests, and drives the board status LEDs (green heartbeat, red fault).

---
 rtl/pano_init_seq.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pano_init_seq.sv
// pano_init_seq: power-up reset sequencer with lock monitor, heartbeat and fault LEDs.
// Define PANO_INIT_SEQ_FAULT_LATCH_EN to make lock-loss faults sticky until fault_clr.
module pano_init_seq #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int NUM_DOMAINS = 3,
  parameter int HEARTBEAT_BITS = 24
) (
  input  logic                   osc_clk,
  input  logic                   reset_n,
  input  logic                   pll_locked,
  input  logic                   sw_reset_req,
  input  logic                   fault_clr,
  output logic [NUM_DOMAINS-1:0] domain_reset_n,
  output logic                   init_done,
  output logic                   led_green,
  output logic                   led_red,
  output logic [7:0]             fault_count
);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES);
  localparam int HW = $clog2(RST_HOLD_CYCLES);
  localparam int IW = $clog2(NUM_DOMAINS + 1);
  localparam logic [1:0] WAIT_LOCK = 2'd0;
  localparam logic [1:0] RELEASE   = 2'd1;
  localparam logic [1:0] RUNNING   = 2'd2;
  localparam logic [1:0] FAULT     = 2'd3;

  logic [1:0]                sync_q;
  logic [1:0]                state_q, state_d;
  logic [SW-1:0]             stab_q, stab_d;
  logic [HW-1:0]             hold_q, hold_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [NUM_DOMAINS-1:0]    dom_q, dom_d;
  logic                      done_q, done_d;
  logic                      red_q, red_d;
  logic [7:0]                fcnt_q, fcnt_d;
  logic [HEARTBEAT_BITS-1:0] hb_q, hb_d;
  logic                      locked_s;

  assign locked_s = sync_q[1];
  assign hb_d = hb_q + HEARTBEAT_BITS'(1);

`ifndef PANO_INIT_SEQ_FAULT_LATCH_EN
  logic unused_fault_clr;
  assign unused_fault_clr = fault_clr;
`endif

  always_comb begin
    state_d = state_q;
    stab_d = stab_q;
    hold_d = hold_q;
    idx_d = idx_q;
    dom_d = dom_q;
    done_d = done_q;
    red_d = red_q;
    fcnt_d = fcnt_q;
    if (state_q == WAIT_LOCK) begin
      stab_d = locked_s ? stab_q + SW'(1) : '0;
      if (locked_s && stab_q == SW'(LOCK_STABLE_CYCLES - 1)) begin
        state_d = RELEASE;
        stab_d = '0;
        hold_d = '0;
        idx_d = '0;
      end
    end else if (state_q == FAULT) begin
      stab_d = '0;
`ifdef PANO_INIT_SEQ_FAULT_LATCH_EN
      state_d = fault_clr ? WAIT_LOCK : FAULT;
`else
      state_d = WAIT_LOCK;
`endif
    end else if (!locked_s) begin
      // lock loss outranks a coincident software request
      state_d = FAULT;
      dom_d = '0;
      done_d = 1'b0;
      red_d = 1'b1;
      fcnt_d = fcnt_q + 8'(fcnt_q != 8'hff);
    end else if (sw_reset_req) begin
      state_d = WAIT_LOCK;
      dom_d = '0;
      done_d = 1'b0;
      stab_d = '0;
    end else if (state_q == RELEASE) begin
      hold_d = hold_q + HW'(1);
      if (hold_q == HW'(RST_HOLD_CYCLES - 1)) begin
        hold_d = '0;
        idx_d = idx_q + IW'(1);
        dom_d = dom_q | (NUM_DOMAINS'(1) << idx_q);
        if (idx_q == IW'(NUM_DOMAINS - 1)) begin
          state_d = RUNNING;
          done_d = 1'b1;
          red_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge osc_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      state_q <= WAIT_LOCK;
      stab_q <= '0;
      hold_q <= '0;
      idx_q <= '0;
      dom_q <= '0;
      done_q <= 1'b0;
      red_q <= 1'b0;
      fcnt_q <= '0;
      hb_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
      state_q <= state_d;
      stab_q <= stab_d;
      hold_q <= hold_d;
      idx_q <= idx_d;
      dom_q <= dom_d;
      done_q <= done_d;
      red_q <= red_d;
      fcnt_q <= fcnt_d;
      hb_q <= hb_d;
    end
  end

  assign domain_reset_n = dom_q;
  assign init_done = done_q;
  assign led_red = red_q;
  assign fault_count = fcnt_q;
  assign led_green = (state_q == RUNNING) ? hb_q[HEARTBEAT_BITS-1] : 1'b0;
endmodule
